// File: rtl/mem_arbiter.sv
// Registered round-robin arbiter between per-core I/D cache ports and one RAM port.
// Holds the granted request on the RAM bus until ACCESS, ERROR, timeout or requester drop.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        D_WR = 2'd0,
        D_RD = 2'd1,
        I_RD = 2'd2
    } src_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate,
    output logic                  timeout_err
);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_gcore;
    src_t            r_gsrc;
    logic [CW-1:0]   r_last;
    logic [TW-1:0]   r_cnt;
    logic            r_timeout_err;

    state_t          w_nxt_state;
    logic [CW-1:0]   w_nxt_gcore;
    src_t            w_nxt_gsrc;
    logic [CW-1:0]   w_nxt_last;
    logic [TW-1:0]   w_nxt_cnt;
    logic            w_nxt_timeout_err;

    logic [CPUS-1:0] w_core_req;
    logic [CW-1:0]   w_idx;
    logic [CW-1:0]   w_pick_core;
    logic            w_pick_valid;
    src_t            w_pick_src;
    logic            w_src_active;

    assign w_core_req  = iREN | dREN | dWEN;
    assign iload       = {CPUS{ramload}};
    assign dload       = {CPUS{ramload}};
    assign timeout_err = r_timeout_err;

    // Rotating search: the core just after the last completed grant gets first look.
    // NOTE: every variable written in always_comb gets a default at the top; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        w_idx        = '0;
        w_pick_core  = '0;
        w_pick_valid = 1'b0;
        for (int i = 1; i <= CPUS; i++) begin
            w_idx = CW'((int'(r_last) + i) % CPUS);
            if (!w_pick_valid && w_core_req[w_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_core  = w_idx;
            end
        end
    end

    always_comb begin
        if (dWEN[w_pick_core])      w_pick_src = D_WR;
        else if (dREN[w_pick_core]) w_pick_src = D_RD;
        else                        w_pick_src = I_RD;
    end

    always_comb begin
        case (r_gsrc)
            D_WR:    w_src_active = dWEN[r_gcore];
            D_RD:    w_src_active = dREN[r_gcore];
            default: w_src_active = iREN[r_gcore];
        endcase
    end

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_gcore       = r_gcore;
        w_nxt_gsrc        = r_gsrc;
        w_nxt_last        = r_last;
        w_nxt_cnt         = r_cnt;
        w_nxt_timeout_err = r_timeout_err;
        ramREN            = 1'b0;
        ramWEN            = 1'b0;
        ramaddr           = '0;
        ramstore          = '0;
        iwait             = '1;
        dwait             = '1;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_nxt_gcore = w_pick_core;
                    w_nxt_gsrc  = w_pick_src;
                    w_nxt_cnt   = '0;
                    w_nxt_state = REQ;
                end
            end
            REQ: begin
                case (r_gsrc)
                    D_WR: begin
                        ramWEN   = 1'b1;
                        ramaddr  = daddr[r_gcore];
                        ramstore = dstore[r_gcore];
                    end
                    D_RD: begin
                        ramREN  = 1'b1;
                        ramaddr = daddr[r_gcore];
                    end
                    default: begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr[r_gcore];
                    end
                endcase

                // A dropped request is abandoned silently and does not advance the rotation.
                if (!w_src_active) begin
                    w_nxt_state = IDLE;
                end else if (ramstate == ERROR) begin
                    w_nxt_state       = IDLE;
                    w_nxt_timeout_err = 1'b1;
                    w_nxt_last        = r_gcore;
                end else if (ramstate == ACCESS) begin
                    if (nRST) begin
                        if (r_gsrc == I_RD) iwait[r_gcore] = 1'b0;
                        else                dwait[r_gcore] = 1'b0;
                    end
                    w_nxt_last  = r_gcore;
                    w_nxt_state = IDLE;
                end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                    w_nxt_state       = IDLE;
                    w_nxt_timeout_err = 1'b1;
                    w_nxt_last        = r_gcore;
                end else begin
                    w_nxt_cnt = r_cnt + TW'(1);
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state       <= IDLE;
            r_gcore       <= '0;
            r_gsrc        <= D_WR;
            r_last        <= CW'(CPUS - 1);
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_gcore       <= w_nxt_gcore;
            r_gsrc        <= w_nxt_gsrc;
            r_last        <= w_nxt_last;
            r_cnt         <= w_nxt_cnt;
            r_timeout_err <= w_nxt_timeout_err;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus a hand-written
// sequence for ACCESS arriving on the final count before timeout.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int CPUS = 2;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [CPUS-1:0]       iREN;
    logic [CPUS-1:0]       dREN;
    logic [CPUS-1:0]       dWEN;
    logic [CPUS-1:0][31:0] iaddr;
    logic [CPUS-1:0][31:0] daddr;
    logic [CPUS-1:0][31:0] dstore;
    logic [CPUS-1:0]       iwait;
    logic [CPUS-1:0]       dwait;
    logic [CPUS-1:0][31:0] iload;
    logic [CPUS-1:0][31:0] dload;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    ramstate_t             ramstate;
    logic                  timeout_err;

    mem_arbiter #(.CPUS(CPUS), .TIMEOUT(8)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .iaddr       (iaddr),
        .daddr       (daddr),
        .dstore      (dstore),
        .iwait       (iwait),
        .dwait       (dwait),
        .iload       (iload),
        .dload       (dload),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [1:0] iren;
        logic [1:0] dren;
        logic [1:0] dwen;
        ramstate_t  rs;
        logic [1:0] iw;
        logic [1:0] dw;
        logic       ren;
        logic       wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic       terr;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic rst_n, input logic [1:0] iren,
                                input logic [1:0] dren, input logic [1:0] dwen, input ramstate_t rs,
                                input logic [1:0] iw, input logic [1:0] dw, input logic ren,
                                input logic wen, input logic [31:0] addr, input logic [31:0] store,
                                input logic terr);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
        v.iw = iw; v.dw = dw; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.terr = terr;
        return v;
    endfunction

    // Expected outputs of the IDLE state: all waits high, RAM bus quiet.
    function automatic vec_t idle(input string name, input logic rst_n, input logic [1:0] iren,
                                  input logic [1:0] dren, input logic [1:0] dwen,
                                  input ramstate_t rs, input logic terr);
        return mk(name, rst_n, iren, dren, dwen, rs, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, terr);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        iaddr    = '{32'h0000_0200, 32'h0000_0100};
        daddr    = '{32'h0000_0080, 32'h0000_0040};
        dstore   = '{32'h0000_BEEF, 32'h0000_DEAD};
        ramload  = 32'hA5A5_0001;
        nRST     = 1'b0;
        iREN     = '0;
        dREN     = 2'b11;
        dWEN     = '0;
        ramstate = FREE;

        // Reset held with requests pending, then core 0 wins the first arbitration.
        vecs.push_back(idle("rst_a",   1'b0, 2'b00, 2'b11, 2'b00, FREE, 1'b0));
        vecs.push_back(idle("rst_b",   1'b0, 2'b00, 2'b11, 2'b00, FREE, 1'b0));
        vecs.push_back(idle("rst_rel", 1'b1, 2'b00, 2'b11, 2'b00, FREE, 1'b0));
        vecs.push_back(mk("first_grant", 1'b1, 2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b10, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0));
        vecs.push_back(idle("gap0",    1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b0));

        // Write beats read beats fetch within core 0; ACCESS after three BUSY cycles.
        vecs.push_back(idle("prio_arb", 1'b1, 2'b01, 2'b01, 2'b01, FREE, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk($sformatf("prio_busy%0d", i), 1'b1, 2'b01, 2'b01, 2'b01, BUSY, 2'b11, 2'b11, 1'b0, 1'b1, 32'h40, 32'h0000_DEAD, 1'b0));
        vecs.push_back(mk("prio_acc", 1'b1, 2'b01, 2'b01, 2'b01, ACCESS, 2'b11, 2'b10, 1'b0, 1'b1, 32'h40, 32'h0000_DEAD, 1'b0));
        vecs.push_back(idle("prio_done", 1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b0));

        // Core 1 drops its read mid-transaction (even with ACCESS): no release, rotation unchanged.
        vecs.push_back(idle("abort_arb", 1'b1, 2'b00, 2'b10, 2'b00, FREE, 1'b0));
        vecs.push_back(mk("abort_busy", 1'b1, 2'b00, 2'b10, 2'b00, BUSY, 2'b11, 2'b11, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0));
        vecs.push_back(mk("abort_drop", 1'b1, 2'b00, 2'b00, 2'b00, ACCESS, 2'b11, 2'b11, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0));
        vecs.push_back(idle("rereq_arb", 1'b1, 2'b00, 2'b11, 2'b00, FREE, 1'b0));
        vecs.push_back(mk("rereq_acc", 1'b1, 2'b00, 2'b11, 2'b00, ACCESS, 2'b11, 2'b01, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0));
        vecs.push_back(idle("rereq_done", 1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b0));

        // Both cores fetching with single-cycle ACCESS: strict alternation, IDLE between grants.
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(idle($sformatf("rr_idle%0d", i), 1'b1, 2'b11, 2'b00, 2'b00, ACCESS, 1'b0));
            if (i % 2 == 0)
                vecs.push_back(mk($sformatf("rr_grant%0d", i), 1'b1, 2'b11, 2'b00, 2'b00, ACCESS, 2'b10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0));
            else
                vecs.push_back(mk($sformatf("rr_grant%0d", i), 1'b1, 2'b11, 2'b00, 2'b00, ACCESS, 2'b01, 2'b11, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0));
        end
        vecs.push_back(idle("rr_done", 1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b0));

        // ERROR aborts and sets the sticky flag; only reset clears it.
        vecs.push_back(idle("err_arb", 1'b1, 2'b00, 2'b01, 2'b00, FREE, 1'b0));
        vecs.push_back(mk("err_req", 1'b1, 2'b00, 2'b01, 2'b00, ERROR, 2'b11, 2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0));
        vecs.push_back(idle("err_sticky", 1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b1));
        vecs.push_back(idle("err_rst",    1'b0, 2'b00, 2'b00, 2'b00, FREE, 1'b1));
        vecs.push_back(idle("err_clr",    1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b0));

        // Core 1 write with RAM BUSY forever: exactly 8 REQ cycles, then abort.
        vecs.push_back(idle("to_arb", 1'b1, 2'b00, 2'b00, 2'b10, FREE, 1'b0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("to_busy%0d", i), 1'b1, 2'b00, 2'b00, 2'b10, BUSY, 2'b11, 2'b11, 1'b0, 1'b1, 32'h80, 32'h0000_BEEF, 1'b0));
        vecs.push_back(idle("to_abort", 1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b1));

        // Reset coinciding with ACCESS: no wait released, reset state next cycle.
        vecs.push_back(idle("mr_arb", 1'b1, 2'b00, 2'b01, 2'b00, FREE, 1'b1));
        vecs.push_back(mk("mr_rst", 1'b0, 2'b00, 2'b01, 2'b00, ACCESS, 2'b11, 2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1));
        vecs.push_back(idle("mr_after", 1'b1, 2'b00, 2'b00, 2'b00, FREE, 1'b0));

        step();
        foreach (vecs[k]) begin
            nRST     = vecs[k].rst_n;
            iREN     = vecs[k].iren;
            dREN     = vecs[k].dren;
            dWEN     = vecs[k].dwen;
            ramstate = vecs[k].rs;
            @(negedge CLK);
            check({vecs[k].name, ".iwait"},    32'(iwait),       32'(vecs[k].iw));
            check({vecs[k].name, ".dwait"},    32'(dwait),       32'(vecs[k].dw));
            check({vecs[k].name, ".ramREN"},   32'(ramREN),      32'(vecs[k].ren));
            check({vecs[k].name, ".ramWEN"},   32'(ramWEN),      32'(vecs[k].wen));
            check({vecs[k].name, ".ramaddr"},  ramaddr,          vecs[k].addr);
            check({vecs[k].name, ".ramstore"}, ramstore,         vecs[k].store);
            check({vecs[k].name, ".terr"},     32'(timeout_err), 32'(vecs[k].terr));
            step();
        end

        // ACCESS on the last count before timeout completes normally; load is broadcast.
        dREN     = 2'b01;
        ramstate = FREE;
        step();
        for (int i = 0; i < 7; i++) begin
            ramstate = BUSY;
            @(negedge CLK);
            check($sformatf("edge_busy%0d.ramREN", i), 32'(ramREN), 32'd1);
            check($sformatf("edge_busy%0d.dwait", i),  32'(dwait),  32'(2'b11));
            step();
        end
        ramstate = ACCESS;
        ramload  = 32'h1234_5678;
        @(negedge CLK);
        check("edge_acc.dwait",  32'(dwait),       32'(2'b10));
        check("edge_acc.terr",   32'(timeout_err), 32'd0);
        check("edge_acc.iload1", iload[1],         32'h1234_5678);
        check("edge_acc.dload0", dload[0],         32'h1234_5678);
        step();
        dREN     = 2'b00;
        ramstate = FREE;
        @(negedge CLK);
        check("edge_done.ramREN", 32'(ramREN),      32'd0);
        check("edge_done.dwait",  32'(dwait),       32'(2'b11));
        check("edge_done.terr",   32'(timeout_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
